// File: rtl/kgp_decode_stage.sv
// kgp_decode_stage
// ----------------
// Instruction-decode stage of the KGPMini pipeline. It takes one instruction
// word and its PC from fetch, decodes the opcode, and holds the result in a
// single-entry output register for the ALU control unit.
//
// Handshake (both sides): a beat moves when valid && ready on the same rising
// edge. The producer holds its payload stable while valid=1 and ready=0. The
// consumer may change ready at any time. The input side accepts whenever
// the stage is running and the output register is empty or draining this
// cycle, so back-to-back beats stream at full rate.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   fetch handshake; instr and pc_in are its payload
//   out_valid/out_ready downstream handshake for the decoded bundle
//   alu_op, funct       ALU operation class and funct field
//   reg_write, mem_read, mem_write, alu_src, branch   datapath controls
//   pc_out              PC of the bundle in the output register
//   halted              HALT has retired; the stage accepts nothing until reset
//   illegal             bundle in the output register had an unknown opcode
//   illegal_cnt         saturating count of accepted illegal opcodes
//   dbg_state           current FSM state (0=RUN, 1=HALTED_PEND, 2=HALTED)

module kgp_decode_stage #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [PC_W-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       alu_op,
  output logic [5:0]       funct,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             branch,
  output logic [PC_W-1:0]  pc_out,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    HALTED_PEND = 2'd1,
    HALTED      = 2'd2
  } state_e;

  localparam logic [5:0]       OP_RTYPE  = 6'b000000;
  localparam logic [5:0]       OP_ADDI   = 6'b000001;
  localparam logic [5:0]       OP_LD     = 6'b000010;
  localparam logic [5:0]       OP_ST     = 6'b000011;
  localparam logic [5:0]       OP_BR     = 6'b000100;
  localparam logic [5:0]       OP_SHIFTI = 6'b000101;
  localparam logic [5:0]       OP_HALT   = 6'b000110;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Registered state
  state_e            state_q,       state_d;
  logic              out_valid_q,   out_valid_d;
  logic [2:0]        alu_op_q,      alu_op_d;
  logic [5:0]        funct_q,       funct_d;
  logic              reg_write_q,   reg_write_d;
  logic              mem_read_q,    mem_read_d;
  logic              mem_write_q,   mem_write_d;
  logic              alu_src_q,     alu_src_d;
  logic              branch_q,      branch_d;
  logic [PC_W-1:0]   pc_q,          pc_d;
  logic              halted_q,      halted_d;
  logic              illegal_q,     illegal_d;
  logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

  // Combinational decode of the incoming word
  logic [5:0] opcode;
  logic [2:0] dec_alu_op;
  logic [5:0] dec_funct;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_alu_src;
  logic       dec_branch;
  logic       dec_halt;
  logic       dec_illegal;

  logic accept;
  logic xfer;

  assign opcode = instr[31:26];

  always_comb begin
    dec_alu_op    = 3'b000;
    dec_funct     = 6'b000000;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_branch    = 1'b0;
    dec_halt      = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_alu_op    = 3'b111;
        dec_funct     = instr[5:0];
        dec_reg_write = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_op    = 3'b001;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_LD: begin
        dec_alu_op    = 3'b010;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_ST: begin
        dec_alu_op    = 3'b010;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_BR: begin
        dec_alu_op = 3'b100;
        dec_funct  = instr[5:0];
        dec_branch = 1'b1;
      end
      OP_SHIFTI: begin
        dec_alu_op    = 3'b011;
        dec_funct     = instr[5:0];
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_HALT: begin
        dec_halt = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // in_ready is forced low while reset is asserted so fetch never sees a
  // ready window before the stage is actually out of reset.
  assign in_ready = rst_n && (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    alu_op_d      = alu_op_q;
    funct_d       = funct_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    alu_src_d     = alu_src_q;
    branch_d      = branch_q;
    pc_d          = pc_q;
    halted_d      = halted_q;
    illegal_d     = illegal_q;
    illegal_cnt_d = illegal_cnt_q;

    if (accept) begin
      // Accept wins over a simultaneous transfer: the new bundle replaces
      // the departing one on the same edge.
      out_valid_d = 1'b1;
      alu_op_d    = dec_alu_op;
      funct_d     = dec_funct;
      reg_write_d = dec_reg_write;
      mem_read_d  = dec_mem_read;
      mem_write_d = dec_mem_write;
      alu_src_d   = dec_alu_src;
      branch_d    = dec_branch;
      pc_d        = pc_in;
      illegal_d   = dec_illegal;
      if (dec_illegal && (illegal_cnt_q != CNT_MAX)) begin
        illegal_cnt_d = illegal_cnt_q + CNT_ONE;
      end
      if (dec_halt) begin
        state_d = HALTED_PEND;
      end
    end else if (xfer) begin
      // Payload fields hold; only valid drops.
      out_valid_d = 1'b0;
      if (state_q == HALTED_PEND) begin
        state_d  = HALTED;
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      out_valid_q   <= 1'b0;
      alu_op_q      <= 3'b000;
      funct_q       <= 6'b000000;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      alu_src_q     <= 1'b0;
      branch_q      <= 1'b0;
      pc_q          <= '0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      alu_op_q      <= alu_op_d;
      funct_q       <= funct_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      alu_src_q     <= alu_src_d;
      branch_q      <= branch_d;
      pc_q          <= pc_d;
      halted_q      <= halted_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_op      = alu_op_q;
  assign funct       = funct_q;
  assign reg_write   = reg_write_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign alu_src     = alu_src_q;
  assign branch      = branch_q;
  assign pc_out      = pc_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = illegal_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_kgp_decode_stage.sv
module tb_kgp_decode_stage;

  localparam int PC_W  = 32;
  localparam int CNT_W = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [PC_W-1:0]  pc_in;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             alu_src;
  logic             branch;
  logic [PC_W-1:0]  pc_out;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;
  logic [1:0]       dbg_state;

  kgp_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc_in      (pc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_op     (alu_op),
    .funct      (funct),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .branch     (branch),
    .pc_out     (pc_out),
    .halted     (halted),
    .illegal    (illegal),
    .illegal_cnt(illegal_cnt),
    .dbg_state  (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Controls packed as {reg_write, mem_read, mem_write, alu_src, branch}
  task automatic check_bundle(input string tag, input logic [2:0] e_op, input logic [5:0] e_funct,
                              input logic [4:0] e_ctl, input logic [PC_W-1:0] e_pc,
                              input logic e_ill);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".alu_op"},    64'(alu_op),    64'(e_op));
    check({tag, ".funct"},     64'(funct),     64'(e_funct));
    check({tag, ".ctl"},       64'({reg_write, mem_read, mem_write, alu_src, branch}), 64'(e_ctl));
    check({tag, ".pc_out"},    64'(pc_out),    64'(e_pc));
    check({tag, ".illegal"},   64'(illegal),   64'(e_ill));
  endtask

  initial begin
    // ---------------- reset with in_valid high ----------------
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h0000_0015;
    pc_in     = 32'h0000_0000;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst.out_valid",   64'(out_valid),   64'd0);
    check("rst.in_ready",    64'(in_ready),    64'd0);
    check("rst.alu_op",      64'(alu_op),      64'd0);
    check("rst.funct",       64'(funct),       64'd0);
    check("rst.ctl",         64'({reg_write, mem_read, mem_write, alu_src, branch}), 64'd0);
    check("rst.pc_out",      64'(pc_out),      64'd0);
    check("rst.halted",      64'(halted),      64'd0);
    check("rst.illegal",     64'(illegal),     64'd0);
    check("rst.illegal_cnt", 64'(illegal_cnt), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("rst.in_ready_after", 64'(in_ready), 64'd1);

    // ---------------- R-type ----------------
    step();
    instr = 32'h0000_0015; pc_in = 32'h100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_bundle("rtype", 3'b111, 6'b010101, 5'b10000, 32'h100, 1'b0);

    // ---------------- back-to-back stream ----------------
    step();
    check("drain.out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1; instr = 32'h0400_002A; pc_in = 32'h200;   // ADDI, funct bits ignored
    step();
    check_bundle("addi", 3'b001, 6'd0, 5'b10010, 32'h200, 1'b0);
    check("addi.in_ready", 64'(in_ready), 64'd1);
    instr = 32'h0800_0000; pc_in = 32'h204;                    // LD
    step();
    check_bundle("ld", 3'b010, 6'd0, 5'b11010, 32'h204, 1'b0);
    instr = 32'h0C00_0000; pc_in = 32'h208;                    // ST
    step();
    check_bundle("st", 3'b010, 6'd0, 5'b00110, 32'h208, 1'b0);
    instr = 32'h1000_0005; pc_in = 32'h20C;                    // BR
    step();
    check_bundle("br", 3'b100, 6'b000101, 5'b00001, 32'h20C, 1'b0);
    instr = 32'h1400_0003; pc_in = 32'h210;                    // SHIFTI
    step();
    check_bundle("shifti", 3'b011, 6'b000011, 5'b10010, 32'h210, 1'b0);
    in_valid = 1'b0;
    step();
    check("stream.drain", 64'(out_valid), 64'd0);
    check("stream.hold_op", 64'(alu_op), 64'd3);

    // ---------------- backpressure ----------------
    in_valid = 1'b1; instr = 32'h0800_0000; pc_in = 32'h300;   // LD
    step();
    out_ready = 1'b0;
    instr = 32'hxxxx_xxxx; pc_in = 'x;                         // X while not ready
    #1;
    check("bp.in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_bundle("bp.stall", 3'b010, 6'd0, 5'b11010, 32'h300, 1'b0);
      check("bp.stall_ready", 64'(in_ready), 64'd0);
      check("bp.state", 64'(dbg_state), 64'd0);
    end
    instr = 32'h0400_0000; pc_in = 32'h304;                    // ADDI
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_bundle("bp.next", 3'b001, 6'd0, 5'b10010, 32'h304, 1'b0);
    step();
    check("bp.drain", 64'(out_valid), 64'd0);
    check("bp.hold_pc", 64'(pc_out), 64'h304);

    // ---------------- illegal saturation ----------------
    in_valid = 1'b1; instr = 32'hFC00_0000;
    for (int i = 0; i < 260; i++) begin
      pc_in = 32'h1000 + 32'(i);
      step();
      check_bundle("ill", 3'b000, 6'd0, 5'b00000, 32'h1000 + 32'(i), 1'b1);
      check("ill.cnt", 64'(illegal_cnt), 64'((i + 1 > 255) ? 255 : i + 1));
    end
    instr = 32'h0400_0000; pc_in = 32'h2000;
    step();
    in_valid = 1'b0;
    check_bundle("ill.clear", 3'b001, 6'd0, 5'b10010, 32'h2000, 1'b0);
    check("ill.cnt_hold", 64'(illegal_cnt), 64'd255);
    step();

    // ---------------- halt ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h1800_0000; pc_in = 32'h3000;
    step();
    check_bundle("halt", 3'b000, 6'd0, 5'b00000, 32'h3000, 1'b0);
    check("halt.in_ready", 64'(in_ready), 64'd0);
    check("halt.halted_pend", 64'(halted), 64'd0);
    check("halt.state_pend", 64'(dbg_state), 64'd1);
    instr = 32'h0400_0000; pc_in = 32'h3004;                   // ADDI offered
    step();
    check("halt.addi_blocked", 64'(in_ready), 64'd0);
    check("halt.pc_hold", 64'(pc_out), 64'h3000);
    out_ready = 1'b1;
    #1;
    check("halt.ready_xfer", 64'(in_ready), 64'd0);
    step();
    check("halt.halted", 64'(halted), 64'd1);
    check("halt.out_valid", 64'(out_valid), 64'd0);
    check("halt.state", 64'(dbg_state), 64'd2);
    repeat (3) step();
    check("halt.frozen_valid", 64'(out_valid), 64'd0);
    check("halt.frozen_ready", 64'(in_ready), 64'd0);
    check("halt.frozen_pc", 64'(pc_out), 64'h3000);
    check("halt.frozen_cnt", 64'(illegal_cnt), 64'd255);

    // ---------------- reset exits halt ----------------
    rst_n = 1'b0;
    #2;
    check("hrst.halted", 64'(halted), 64'd0);
    check("hrst.cnt", 64'(illegal_cnt), 64'd0);
    check("hrst.state", 64'(dbg_state), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("hrst.in_ready", 64'(in_ready), 64'd1);
    step();
    check_bundle("hrst.addi", 3'b001, 6'd0, 5'b10010, 32'h3004, 1'b0);

    // ---------------- reset discards a pending bundle ----------------
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("mid.held", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("mid.discard", 64'(out_valid), 64'd0);
    check("mid.pc", 64'(pc_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kgp_decode_stage.md
Name: kgp_decode_stage

Overview:
- Instruction-decode pipeline stage of the KGPMini RISC processor. Sits between instruction fetch and the ALU control unit.
- Accepts a 32-bit instruction and its PC over a valid/ready handshake and decodes the opcode.
- Registers the 3-bit ALU operation class and the 6-bit funct field that the ALU control unit consumes, together with the datapath control bits.
- Handles halt and illegal-opcode detection.

Parameters:
- PC_W, 32, width of the program counter carried with each instruction
- CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept an instruction this cycle
- instr  input  32  instruction word; opcode = instr[31:26], funct = instr[5:0]
- pc_in  input  PC_W  PC of instr
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts bundle
- alu_op  output  3  ALU operation class to ALU control
- funct  output  6  funct field to ALU control
- reg_write, mem_read, mem_write, alu_src, branch  output  1 each  datapath controls
- pc_out  output  PC_W  PC of the decoded instruction
- halted  output  1  HALT retired; stage frozen
- illegal  output  1  current bundle carries an illegal opcode
- illegal_cnt  output  CNT_W  saturating count of accepted illegal opcodes

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, including out_valid, halted, illegal, illegal_cnt and all control bits. FSM enters RUN.
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready). This is a single-entry register.
- Full-throughput back-to-back transfers are allowed when out_ready=1.
- Latency: a bundle accepted at edge N is visible at the outputs with out_valid=1 after edge N. Latency is 1 cycle.
- Output register update rules:
  - On accept, the output register loads the new bundle and out_valid=1.
  - On transfer without accept, out_valid→0. The other outputs hold their values.
  - With out_valid=1 and out_ready=0, every output is stable until transfer.
- Decode map (opcode → alu_op, funct, controls):
  - 000000 R-type → 111, instr[5:0], reg_write
  - 000001 ADDI → 001, 000000, reg_write+alu_src
  - 000010 LD → 010, 000000, reg_write+mem_read+alu_src
  - 000011 ST → 010, 000000, mem_write+alu_src
  - 000100 BR → 100, instr[5:0], branch
  - 000101 SHIFTI → 011, instr[5:0], reg_write+alu_src
  - 000110 HALT → 000, 000000, no controls; state→HALTED_PEND on accept
  - any other opcode → 000, 000000, no controls, illegal=1
- illegal_cnt increments on accept of an illegal opcode. It saturates at 2^CNT_W−1 and holds there.
- FSM states:
  - RUN: normal operation.
  - HALTED_PEND: HALT bundle is in the output register. in_ready=0. Go to HALTED on transfer of that bundle.
  - HALTED: halted=1, in_ready=0, out_valid=0. Exit only via reset.
- Simultaneous transfer and accept in RUN: the new bundle replaces the old one in the same edge. No bubble.
- Reset mid-operation: a pending bundle is discarded and is not replayed.
- in_valid with X instr while in_ready=0 must not affect state.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, in_ready=0 while rst_n=0, all outputs 0. Release rst_n → in_ready=1.
- R-type: instr=0x00000015, out_ready=1 → next cycle out_valid=1, alu_op=111, funct=010101, reg_write=1, alu_src=0.
- Back-to-back streaming: ADDI, LD (0x08000000), ST (0x0C000000), BR (0x10000005) on consecutive cycles → four consecutive bundles in order. ST shows alu_op=010, mem_write=1, reg_write=0. BR shows alu_op=100, funct=000101, branch=1.
- Backpressure: accept LD, then out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable for 3 cycles. On out_ready=1 the next instruction is accepted in the same edge.
- Illegal saturation: issue opcode 111111 260 times with CNT_W=8 → illegal=1 on each bundle, all controls 0, illegal_cnt=255.
- Halt: accept HALT (0x18000000), then offer ADDI → in_ready=0. After HALT transfer, halted=1 and out_valid=0. ADDI is never accepted until reset; after reset halted=0 and illegal_cnt=0.
